// File: rtl/usr_access_reader_if.sv
`timescale 1ns/1ps
// Register read port between the management logic (master) and the
// user-access reader (slave): single-cycle request, one-cycle acknowledge.
interface usr_access_reader_if;
  logic        rd_req;
  logic [1:0]  rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_data
  );
endinterface

// File: rtl/usr_access_reader.sv
`timescale 1ns/1ps
// Consumer of the configuration user-access word. Synchronises DATA/DATAVALID,
// qualifies the word by a run of identical samples, holds a locked copy,
// decodes it as a build timestamp and serves it on a small read port.
module usr_access_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic [31:0] ID_WORD       = 32'h5541_4331
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                usr_data,
  input  logic                       usr_datavalid,
  usr_access_reader_if.slave         bus,
  output logic                       locked,
  output logic [31:0]                cap_data,
  output logic [4:0]                 ts_day,
  output logic [3:0]                 ts_month,
  output logic [5:0]                 ts_year,
  output logic [4:0]                 ts_hour,
  output logic [5:0]                 ts_min,
  output logic [5:0]                 ts_sec,
  output logic                       ts_plausible
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // Run target widened by one bit so run + 1 never overflows the compare.
  localparam logic [8:0] STABLE_TGT = 9'(STABLE_CYCLES);

  logic        v_meta;
  logic        v_s;
  logic [31:0] d_meta;
  logic [31:0] d_s;

  logic [1:0]  state;
  logic [31:0] ref_word;
  logic [7:0]  run;
  logic [15:0] capture_cnt;
  logic [7:0]  mismatch_cnt;
  logic        valid_ever;
  logic [31:0] cap_reg;

  logic        ack_reg;
  logic [31:0] rdata_reg;
  logic [31:0] rd_mux;

  // Two-flop synchronisers; the primitive's outputs are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_meta <= 1'b0;
      v_s    <= 1'b0;
      d_meta <= '0;
      d_s    <= '0;
    end else begin
      v_meta <= usr_datavalid;
      v_s    <= v_meta;
      d_meta <= usr_data;
      d_s    <= d_meta;
    end
  end

  // Qualification FSM: count identical valid samples, lock, and watch for change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ref_word     <= '0;
      run          <= '0;
      capture_cnt  <= '0;
      mismatch_cnt <= '0;
      valid_ever   <= 1'b0;
      cap_reg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (v_s) begin
            ref_word <= d_s;
            run      <= 8'd1;
            if (STABLE_CYCLES <= 1) begin
              state       <= LOCKED;
              cap_reg     <= d_s;
              capture_cnt <= (capture_cnt == 16'hFFFF) ? capture_cnt : capture_cnt + 16'd1;
              valid_ever  <= 1'b1;
            end else begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (!v_s) begin
            state <= IDLE;
          end else if (d_s != ref_word) begin
            ref_word <= d_s;
            run      <= 8'd1;
          end else begin
            run <= run + 8'd1;
            // >= rather than == so a run target of 1 can still lock from here.
            if ({1'b0, run} + 9'd1 >= STABLE_TGT) begin
              state       <= LOCKED;
              cap_reg     <= ref_word;
              capture_cnt <= (capture_cnt == 16'hFFFF) ? capture_cnt : capture_cnt + 16'd1;
              valid_ever  <= 1'b1;
            end
          end
        end
        LOCKED: begin
          // Loss of valid wins over a simultaneous data change.
          if (!v_s) begin
            state <= IDLE;
          end else if (d_s != cap_reg) begin
            mismatch_cnt <= (mismatch_cnt == 8'hFF) ? mismatch_cnt : mismatch_cnt + 8'd1;
            ref_word     <= d_s;
            run          <= 8'd1;
            state        <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign locked   = (state == LOCKED);
  assign cap_data = cap_reg;

  assign ts_day   = cap_reg[31:27];
  assign ts_month = cap_reg[26:23];
  assign ts_year  = cap_reg[22:17];
  assign ts_hour  = cap_reg[16:12];
  assign ts_min   = cap_reg[11:6];
  assign ts_sec   = cap_reg[5:0];

  assign ts_plausible = (ts_day != 5'd0) &&
                        (ts_month != 4'd0) && (ts_month <= 4'd12) &&
                        (ts_hour < 5'd24) &&
                        (ts_min < 6'd60) &&
                        (ts_sec < 6'd60);

  // Register map decode from the current (pre-edge) state.
  always_comb begin
    rd_mux = '0;
    case (bus.rd_addr)
      2'd0: rd_mux = cap_reg;
      2'd1: rd_mux = {locked, valid_ever, ts_plausible, 5'b0, mismatch_cnt, capture_cnt};
      2'd2: rd_mux = {state, 22'b0, run};
      2'd3: rd_mux = ID_WORD;
      default: rd_mux = '0;
    endcase
  end

  // Read port: acknowledge one cycle after each request, data zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ack_reg   <= bus.rd_req;
      rdata_reg <= bus.rd_req ? rd_mux : 32'd0;
    end
  end

  assign bus.rd_ack  = ack_reg;
  assign bus.rd_data = rdata_reg;

endmodule
